// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined IEEE-754-style multiplier (unpack/classify, significand multiply,
// normalise/round/pack) with valid/ready flow control, RNE rounding, DAZ/FTZ and flags.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in_a,
  input  logic [EXP_W+MAN_W:0] in_b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic [3:0]           out_flags
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int P = 2 * MAN_W + 2;
  localparam int E = EXP_W + 2;
  localparam logic signed [E-1:0] BIAS     = E'((2 ** (EXP_W - 1)) - 1);
  localparam logic signed [E-1:0] EXP_MAX  = E'((2 ** EXP_W) - 1);
  localparam logic signed [E-1:0] EXP_ZERO = {E{1'b0}};
  localparam logic [EXP_W-1:0]    EONES    = {EXP_W{1'b1}};
  localparam logic [W-1:0]        QNAN     = {1'b0, EONES, 1'b1, {(MAN_W-1){1'b0}}};

  logic adv_s;
  assign adv_s    = !out_valid || out_ready;
  assign in_ready = adv_s;

  // ---------------- S1: unpack / classify ----------------
  logic                 sa_s, sb_s, sign_s;
  logic [EXP_W-1:0]     ea_s, eb_s;
  logic [MAN_W-1:0]     fa_s, fb_s;
  logic                 a_nan_s, b_nan_s, a_snan_s, b_snan_s;
  logic                 a_inf_s, b_inf_s, a_zero_s, b_zero_s;
  logic                 spec_s;
  logic [W-1:0]         spec_data_s;
  logic [3:0]           spec_flags_s;

  assign sa_s   = in_a[W-1];
  assign sb_s   = in_b[W-1];
  assign ea_s   = in_a[W-2 -: EXP_W];
  assign eb_s   = in_b[W-2 -: EXP_W];
  assign fa_s   = in_a[MAN_W-1:0];
  assign fb_s   = in_b[MAN_W-1:0];
  assign sign_s = sa_s ^ sb_s;

  assign a_nan_s  = (ea_s == EONES) && (fa_s != {MAN_W{1'b0}});
  assign b_nan_s  = (eb_s == EONES) && (fb_s != {MAN_W{1'b0}});
  assign a_snan_s = a_nan_s && !fa_s[MAN_W-1];
  assign b_snan_s = b_nan_s && !fb_s[MAN_W-1];
  assign a_inf_s  = (ea_s == EONES) && (fa_s == {MAN_W{1'b0}});
  assign b_inf_s  = (eb_s == EONES) && (fb_s == {MAN_W{1'b0}});
  // Subnormal inputs count as zero, so a zero exponent alone classifies the operand.
  assign a_zero_s = (ea_s == {EXP_W{1'b0}});
  assign b_zero_s = (eb_s == {EXP_W{1'b0}});

  // Resolve special operands in precedence order; finite nonzero pairs use the datapath.
  always_comb begin
    spec_s       = 1'b0;
    spec_data_s  = {W{1'b0}};
    spec_flags_s = 4'b0000;
    if (a_snan_s || b_snan_s || (a_inf_s && b_zero_s) || (a_zero_s && b_inf_s)) begin
      spec_s       = 1'b1;
      spec_data_s  = QNAN;
      spec_flags_s = 4'b1000;
    end else if (a_nan_s || b_nan_s) begin
      spec_s      = 1'b1;
      spec_data_s = QNAN;
    end else if (a_inf_s || b_inf_s) begin
      spec_s      = 1'b1;
      spec_data_s = {sign_s, EONES, {MAN_W{1'b0}}};
    end else if (a_zero_s || b_zero_s) begin
      spec_s      = 1'b1;
      spec_data_s = {sign_s, {(W-1){1'b0}}};
    end else begin
      spec_s = 1'b0;
    end
  end

  logic                 s1_valid_r, s1_sign_r, s1_spec_r;
  logic [TAG_W-1:0]     s1_tag_r;
  logic [W-1:0]         s1_spec_data_r;
  logic [3:0]           s1_spec_flags_r;
  logic [EXP_W-1:0]     s1_ea_r, s1_eb_r;
  logic [MAN_W:0]       s1_ma_r, s1_mb_r;

  // Stage-1 register: classified operands with hidden bits restored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r      <= 1'b0;
      s1_sign_r       <= 1'b0;
      s1_spec_r       <= 1'b0;
      s1_tag_r        <= {TAG_W{1'b0}};
      s1_spec_data_r  <= {W{1'b0}};
      s1_spec_flags_r <= 4'b0000;
      s1_ea_r         <= {EXP_W{1'b0}};
      s1_eb_r         <= {EXP_W{1'b0}};
      s1_ma_r         <= {(MAN_W+1){1'b0}};
      s1_mb_r         <= {(MAN_W+1){1'b0}};
    end else if (adv_s) begin
      s1_valid_r      <= in_valid;
      s1_sign_r       <= sign_s;
      s1_spec_r       <= spec_s;
      s1_tag_r        <= in_tag;
      s1_spec_data_r  <= spec_data_s;
      s1_spec_flags_r <= spec_flags_s;
      s1_ea_r         <= ea_s;
      s1_eb_r         <= eb_s;
      s1_ma_r         <= {1'b1, fa_s};
      s1_mb_r         <= {1'b1, fb_s};
    end
  end

  // ---------------- S2: significand multiply ----------------
  logic                 s2_valid_r, s2_sign_r, s2_spec_r;
  logic [TAG_W-1:0]     s2_tag_r;
  logic [W-1:0]         s2_spec_data_r;
  logic [3:0]           s2_spec_flags_r;
  logic signed [E-1:0]  s2_exp_r;
  logic [P-1:0]         s2_prod_r;

  // Stage-2 register: full-width product and unnormalised signed biased exponent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r      <= 1'b0;
      s2_sign_r       <= 1'b0;
      s2_spec_r       <= 1'b0;
      s2_tag_r        <= {TAG_W{1'b0}};
      s2_spec_data_r  <= {W{1'b0}};
      s2_spec_flags_r <= 4'b0000;
      s2_exp_r        <= {E{1'b0}};
      s2_prod_r       <= {P{1'b0}};
    end else if (adv_s) begin
      s2_valid_r      <= s1_valid_r;
      s2_sign_r       <= s1_sign_r;
      s2_spec_r       <= s1_spec_r;
      s2_tag_r        <= s1_tag_r;
      s2_spec_data_r  <= s1_spec_data_r;
      s2_spec_flags_r <= s1_spec_flags_r;
      s2_exp_r        <= $signed(E'(s1_ea_r)) + $signed(E'(s1_eb_r)) - BIAS;
      s2_prod_r       <= P'(s1_ma_r) * P'(s1_mb_r);
    end
  end

  // ---------------- S3: normalise / round / pack ----------------
  logic                 norm_s, guard_s, sticky_s, rnd_up_s, of_s, uf_s;
  logic [P-2:0]         shifted_s;
  logic [MAN_W-1:0]     man_s;
  logic [MAN_W:0]       man_rnd_s;
  logic signed [E-1:0]  exp_fin_s;
  logic [W-1:0]         res_data_s;
  logic [3:0]           res_flags_s;

  // Products in [2,4) drop one more bit; the shifted-in zero never affects sticky.
  assign norm_s    = s2_prod_r[P-1];
  assign shifted_s = norm_s ? s2_prod_r[P-2:0] : {s2_prod_r[P-3:0], 1'b0};
  assign man_s     = shifted_s[P-2 -: MAN_W];
  assign guard_s   = shifted_s[P-2-MAN_W];
  assign sticky_s  = |shifted_s[P-3-MAN_W:0];
  assign rnd_up_s  = guard_s && (sticky_s || man_s[0]);
  assign man_rnd_s = {1'b0, man_s} + {{MAN_W{1'b0}}, rnd_up_s};
  assign exp_fin_s = s2_exp_r + $signed({{(E-1){1'b0}}, norm_s})
                              + $signed({{(E-1){1'b0}}, man_rnd_s[MAN_W]});
  assign of_s      = (exp_fin_s >= EXP_MAX);
  assign uf_s      = (exp_fin_s <= EXP_ZERO);

  // Select final encoding: special result, saturated inf, flushed zero, or normal.
  always_comb begin
    res_data_s  = {W{1'b0}};
    res_flags_s = 4'b0000;
    if (s2_spec_r) begin
      res_data_s  = s2_spec_data_r;
      res_flags_s = s2_spec_flags_r;
    end else if (of_s) begin
      res_data_s  = {s2_sign_r, EONES, {MAN_W{1'b0}}};
      res_flags_s = 4'b0101;
    end else if (uf_s) begin
      res_data_s  = {s2_sign_r, {(W-1){1'b0}}};
      res_flags_s = 4'b0011;
    end else begin
      res_data_s  = {s2_sign_r, exp_fin_s[EXP_W-1:0], man_rnd_s[MAN_W-1:0]};
      res_flags_s = {3'b000, guard_s || sticky_s};
    end
  end

  // Output register: result, tag and flags move together and hold while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= {W{1'b0}};
      out_tag   <= {TAG_W{1'b0}};
      out_flags <= 4'b0000;
    end else if (adv_s) begin
      out_valid <= s2_valid_r;
      out_data  <= res_data_s;
      out_tag   <= s2_tag_r;
      out_flags <= res_flags_s;
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe: directed IEEE cases, randomized streams against an
// integer-arithmetic reference model, stall/backpressure, mid-flight reset and a half-precision build.
module tb_fp_mul_pipe;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv, ir, ov, ordy;
  logic [31:0] ia, ib, od;
  logic [3:0]  itag, otag, oflg;
  logic        hv, hr, hov, hordy;
  logic [15:0] ha, hb, hod;
  logic [3:0]  htag, hotag, hoflg;

  int checks = 0;
  int failures = 0;
  logic [39:0] got_q[$];
  logic [23:0] hgot_q[$];

  fp_mul_pipe dut32 (
    .clk(clk), .rst(rst), .in_valid(iv), .in_ready(ir), .in_a(ia), .in_b(ib), .in_tag(itag),
    .out_valid(ov), .out_ready(ordy), .out_data(od), .out_tag(otag), .out_flags(oflg)
  );

  fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(hv), .in_ready(hr), .in_a(ha), .in_b(hb), .in_tag(htag),
    .out_valid(hov), .out_ready(hordy), .out_data(hod), .out_tag(hotag), .out_flags(hoflg)
  );

  logic [31:0] sp32 [0:7] = '{32'h00000000, 32'h80000000, 32'h7F800000, 32'hFF800000,
                              32'h7FC00000, 32'h7F800001, 32'h00000005, 32'h7F7FFFFF};
  logic [15:0] sp16 [0:7] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00,
                              16'h7E00, 16'h7C01, 16'h0001, 16'h7BFF};

  localparam int ND = 19;
  logic [31:0] dir_a [0:ND-1] = '{32'h3FC00000, 32'h3F800001, 32'h7F800000, 32'h7F000000, 32'h00800000,
                                  32'h3F800001, 32'h3F800003, 32'h7F800001, 32'h7FC00000, 32'hFFC00000,
                                  32'hFF800000, 32'h80000000, 32'h00000001, 32'h7FC00000, 32'h3FFFFFFF,
                                  32'hC0000000, 32'h7F800000, 32'h7F7FFFFF, 32'h00800000};
  logic [31:0] dir_b [0:ND-1] = '{32'h40000000, 32'h3F800001, 32'h00000000, 32'h40000000, 32'h3F000000,
                                  32'h3FC00000, 32'h3FC00000, 32'h3F800000, 32'h7F800001, 32'h40000000,
                                  32'h40000000, 32'h40400000, 32'h7F800000, 32'h7F800000, 32'h3FFFFFFF,
                                  32'h40400000, 32'hFF800000, 32'h3F800000, 32'h40000000};
  logic [31:0] dir_r [0:ND-1] = '{32'h40400000, 32'h3F800002, 32'h7FC00000, 32'h7F800000, 32'h00000000,
                                  32'h3FC00002, 32'h3FC00004, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
                                  32'hFF800000, 32'h80000000, 32'h7FC00000, 32'h7FC00000, 32'h407FFFFE,
                                  32'hC0C00000, 32'hFF800000, 32'h7F7FFFFF, 32'h01000000};
  logic [3:0]  dir_f [0:ND-1] = '{4'h0, 4'h1, 4'h8, 4'h5, 4'h3, 4'h1, 4'h1, 4'h8, 4'h8, 4'h0,
                                  4'h0, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0};

  // Reference: exact integer product, then round-half-even by remainder comparison.
  function automatic logic [35:0] fmul_model(input logic [31:0] a, input logic [31:0] b,
                                             input int ew, input int mw);
    longint av, bv, emax, bias, mmask, sa, sb, sgn, ea, eb, fa, fb;
    longint p, q, r, half, e, sh, qnan, res;
    logic [3:0] fl;
    bit a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    av = longint'(a);
    bv = longint'(b);
    emax  = (64'sd1 << ew) - 64'sd1;
    bias  = (64'sd1 << (ew - 1)) - 64'sd1;
    mmask = (64'sd1 << mw) - 64'sd1;
    sa = (av >> (ew + mw)) & 64'sd1;  sb = (bv >> (ew + mw)) & 64'sd1;
    ea = (av >> mw) & emax;           eb = (bv >> mw) & emax;
    fa = av & mmask;                  fb = bv & mmask;
    sgn = sa ^ sb;
    a_nan = (ea == emax) && (fa != 0);  b_nan = (eb == emax) && (fb != 0);
    a_snan = a_nan && (((fa >> (mw - 1)) & 64'sd1) == 0);
    b_snan = b_nan && (((fb >> (mw - 1)) & 64'sd1) == 0);
    a_inf = (ea == emax) && (fa == 0);  b_inf = (eb == emax) && (fb == 0);
    a_zero = (ea == 0);                 b_zero = (eb == 0);
    qnan = (emax << mw) | (64'sd1 << (mw - 1));
    fl = 4'b0000;
    if (a_snan || b_snan || (a_inf && b_zero) || (a_zero && b_inf)) begin
      res = qnan; fl = 4'b1000;
    end else if (a_nan || b_nan) begin
      res = qnan;
    end else if (a_inf || b_inf) begin
      res = (sgn << (ew + mw)) | (emax << mw);
    end else if (a_zero || b_zero) begin
      res = sgn << (ew + mw);
    end else begin
      p = ((64'sd1 << mw) + fa) * ((64'sd1 << mw) + fb);
      e = ea + eb - bias;
      if (p >= (64'sd1 << (2 * mw + 1))) begin sh = mw + 1; e = e + 1; end
      else sh = mw;
      q = p >> sh;
      r = p - (q << sh);
      half = 64'sd1 << (sh - 1);
      if ((r > half) || ((r == half) && ((q & 64'sd1) == 64'sd1))) q = q + 1;
      if (r != 0) fl = 4'b0001;
      if (q == (64'sd1 << (mw + 1))) begin q = q >> 1; e = e + 1; end
      if (e >= emax) begin
        res = (sgn << (ew + mw)) | (emax << mw); fl = 4'b0101;
      end else if (e <= 0) begin
        res = sgn << (ew + mw); fl = 4'b0011;
      end else begin
        res = (sgn << (ew + mw)) | (e << mw) | (q - (64'sd1 << mw));
      end
    end
    return {fl, res[31:0]};
  endfunction

  function automatic logic [31:0] gen32();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return sp32[$urandom_range(0, 7)];
    else if (k == 1) return $urandom();
    else return {1'($urandom_range(0, 1)), 8'($urandom_range(100, 154)), 23'($urandom())};
  endfunction

  function automatic logic [15:0] gen16();
    int k;
    k = $urandom_range(0, 9);
    if (k == 0) return sp16[$urandom_range(0, 7)];
    else if (k == 1) return 16'($urandom());
    else return {1'($urandom_range(0, 1)), 5'($urandom_range(8, 22)), 10'($urandom())};
  endfunction

  // One clock of the fp32 instance: drive at negedge, sample just after, then wait for the edge.
  task automatic cyc32(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                       input logic rdy, output logic acc, output logic inrdy,
                       output logic ovs, output logic [31:0] ods);
    @(negedge clk);
    iv = v; ia = a; ib = b; itag = tag; ordy = rdy;
    #1;
    acc = iv & ir; inrdy = ir; ovs = ov; ods = od;
    if (ov && ordy) got_q.push_back({od, otag, oflg});
    @(posedge clk);
  endtask

  task automatic cyc16(input logic v, input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                       input logic rdy, output logic acc);
    @(negedge clk);
    hv = v; ha = a; hb = b; htag = tag; hordy = rdy;
    #1;
    acc = hv & hr;
    if (hov && hordy) hgot_q.push_back({hod, hotag, hoflg});
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv = 1'b0; ia = 32'h0; ib = 32'h0; itag = 4'h0; ordy = 1'b1;
    hv = 1'b0; ha = 16'h0; hb = 16'h0; htag = 4'h0; hordy = 1'b1;
    #12;
    checks++; if (ov !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", ov); end
    checks++; if (od !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", od); end
    checks++; if (otag !== 4'h0) begin failures++; $display("FAIL reset_out_tag got=%h exp=0", otag); end
    checks++; if (oflg !== 4'h0) begin failures++; $display("FAIL reset_out_flags got=%h exp=0", oflg); end
    checks++; if (ir !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", ir); end
    checks++; if (hov !== 1'b0) begin failures++; $display("FAIL reset_h_out_valid got=%b exp=0", hov); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic acc, rd, ovs; logic [31:0] ods; logic [39:0] g;
    int lat; bit found;
    got_q.delete();
    for (int i = 0; i < ND; i++) begin
      cyc32(1'b1, dir_a[i], dir_b[i], 4'(i), 1'b1, acc, rd, ovs, ods);
      lat = 0; found = 0;
      while (!found && lat < 10) begin
        cyc32(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, acc, rd, ovs, ods);
        lat++;
        if (got_q.size() > 0) found = 1;
      end
      checks++;
      if (!found) begin
        failures++; $display("FAIL dir%0d_timeout got=none exp=result", i);
      end else begin
        g = got_q.pop_front();
        if (g[39:8] !== dir_r[i]) begin
          failures++; $display("FAIL dir%0d_data a=%h b=%h got=%h exp=%h", i, dir_a[i], dir_b[i], g[39:8], dir_r[i]);
        end
        checks++;
        if (g[3:0] !== dir_f[i]) begin
          failures++; $display("FAIL dir%0d_flags got=%h exp=%h", i, g[3:0], dir_f[i]);
        end
        checks++;
        if (g[7:4] !== 4'(i)) begin
          failures++; $display("FAIL dir%0d_tag got=%h exp=%h", i, g[7:4], 4'(i));
        end
        checks++;
        if (lat != 3) begin
          failures++; $display("FAIL dir%0d_latency got=%0d exp=3", i, lat);
        end
      end
    end
  endtask

  task automatic test_random();
    logic acc, rd, ovs; logic [31:0] ods, a, b; logic [39:0] g, e; logic [35:0] m;
    logic [39:0] exp_q[$];
    logic [3:0] tag;
    int drain;
    got_q.delete();
    tag = 4'h0;
    for (int c = 0; c < 400; c++) begin
      a = gen32(); b = gen32();
      cyc32(1'($urandom_range(0, 3) != 0), a, b, tag, 1'($urandom_range(0, 3) != 0), acc, rd, ovs, ods);
      if (acc) begin
        m = fmul_model(a, b, 8, 23);
        exp_q.push_back({m[31:0], tag, m[35:32]});
        tag = tag + 4'h1;
      end
      while (got_q.size() > 0) begin
        g = got_q.pop_front();
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rand_extra got=%h exp=none", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            failures++; $display("FAIL rand_result got=%h exp=%h (data,tag,flags)", g, e);
          end
        end
      end
    end
    drain = 0;
    while (exp_q.size() > 0 && drain < 20) begin
      cyc32(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, acc, rd, ovs, ods);
      drain++;
      while (got_q.size() > 0 && exp_q.size() > 0) begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        checks++;
        if (g !== e) begin
          failures++; $display("FAIL rand_drain got=%h exp=%h", g, e);
        end
      end
    end
    checks++;
    if (exp_q.size() != 0 || got_q.size() != 0) begin
      failures++; $display("FAIL rand_count missing=%0d extra=%0d exp=0", exp_q.size(), got_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic acc, rd, ovs, rdy; logic [31:0] ods, held; logic [31:0] a [0:5]; logic [31:0] b [0:5];
    logic [39:0] g, e; logic [35:0] m;
    int sent, stalls, k;
    got_q.delete();
    for (int i = 0; i < 6; i++) begin a[i] = gen32(); b[i] = gen32(); end
    sent = 0; stalls = 0; k = 0; held = 32'h0;
    while (got_q.size() < 6 && k < 40) begin
      k++;
      rdy = !(k >= 2 && k <= 6);
      cyc32(sent < 6, (sent < 6) ? a[sent] : 32'h0, (sent < 6) ? b[sent] : 32'h0, 4'(4'hA + sent),
            rdy, acc, rd, ovs, ods);
      if (!rd) stalls++;
      if (k == 4) held = ods;
      if (k == 5 || k == 6) begin
        checks++;
        if (ovs !== 1'b1 || ods !== held) begin
          failures++; $display("FAIL b2b_hold cycle=%0d got=%b/%h exp=1/%h", k, ovs, ods, held);
        end
      end
      if (acc) sent++;
    end
    checks++;
    if (stalls != 3) begin failures++; $display("FAIL b2b_stall_cycles got=%0d exp=3", stalls); end
    checks++;
    if (got_q.size() != 6) begin failures++; $display("FAIL b2b_count got=%0d exp=6", got_q.size()); end
    for (int i = 0; i < 6 && got_q.size() > 0; i++) begin
      g = got_q.pop_front();
      m = fmul_model(a[i], b[i], 8, 23);
      e = {m[31:0], 4'(4'hA + i), m[35:32]};
      checks++;
      if (g !== e) begin failures++; $display("FAIL b2b_result%0d got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_reset_midflight();
    logic acc, rd, ovs; logic [31:0] ods;
    got_q.delete();
    for (int i = 0; i < 3; i++) cyc32(1'b1, gen32(), gen32(), 4'(i), 1'b1, acc, rd, ovs, ods);
    @(negedge clk);
    iv = 1'b0;
    #1;
    checks++;
    if (ov !== 1'b1) begin failures++; $display("FAIL mid_prefill_valid got=%b exp=1", ov); end
    rst = 1'b1;
    #1;
    checks++;
    if (ov !== 1'b0 || od !== 32'h0 || oflg !== 4'h0) begin
      failures++; $display("FAIL mid_async_clear got=%b/%h/%h exp=0/0/0", ov, od, oflg);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) cyc32(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, acc, rd, ovs, ods);
    checks++;
    if (got_q.size() != 0) begin failures++; $display("FAIL mid_stale_results got=%0d exp=0", got_q.size()); end
  endtask

  task automatic test_half();
    logic acc; logic [15:0] a, b; logic [23:0] g, e; logic [35:0] m;
    logic [23:0] exp_q[$];
    logic [15:0] da [0:2] = '{16'h3C00, 16'h7BFF, 16'h3DA8};
    logic [15:0] db [0:2] = '{16'h4000, 16'h4000, 16'h3DA8};
    logic [23:0] de [0:2] = '{{16'h4000, 4'h0, 4'h0}, {16'h7C00, 4'h1, 4'h5}, {16'h4000, 4'h2, 4'h1}};
    int tries, drain;
    hgot_q.delete();
    for (int i = 0; i < 120; i++) begin
      if (i < 3) begin a = da[i]; b = db[i]; exp_q.push_back(de[i]); end
      else begin
        a = gen16(); b = gen16();
        m = fmul_model({16'h0, a}, {16'h0, b}, 5, 10);
        exp_q.push_back({m[15:0], 4'(i), m[35:32]});
      end
      acc = 1'b0; tries = 0;
      while (!acc && tries < 10) begin
        cyc16(1'b1, a, b, 4'(i), 1'($urandom_range(0, 2) != 0), acc);
        tries++;
      end
      checks++;
      if (!acc) begin failures++; $display("FAIL half_accept_timeout op=%0d got=0 exp=1", i); end
      while (hgot_q.size() > 0 && exp_q.size() > 0) begin
        g = hgot_q.pop_front(); e = exp_q.pop_front();
        checks++;
        if (g !== e) begin failures++; $display("FAIL half_result got=%h exp=%h (data,tag,flags)", g, e); end
      end
    end
    drain = 0;
    while (exp_q.size() > 0 && drain < 20) begin
      cyc16(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, acc);
      drain++;
      while (hgot_q.size() > 0 && exp_q.size() > 0) begin
        g = hgot_q.pop_front(); e = exp_q.pop_front();
        checks++;
        if (g !== e) begin failures++; $display("FAIL half_drain got=%h exp=%h", g, e); end
      end
    end
    checks++;
    if (exp_q.size() != 0 || hgot_q.size() != 0) begin
      failures++; $display("FAIL half_count missing=%0d extra=%0d exp=0", exp_q.size(), hgot_q.size());
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midflight();
    test_half();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
